// File: rtl/int_reg_file_rob_if.sv
// Read, commit and rename buses of the integer register file with rename status.
interface int_reg_file_rob_if #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int ROB_W = 4,
   parameter int NRD   = 4,
   parameter int NWR   = 2,
   parameter int NREN  = 2
) ();
   localparam int AW = $clog2(NREG);

   logic [NRD*AW-1:0]     rd_addr;
   logic [NRD*XLEN-1:0]   rd_data;
   logic [NRD*ROB_W-1:0]  rd_tag;
   logic [NRD-1:0]        rd_avail;
   logic [NWR-1:0]        wr_en;
   logic [NWR*AW-1:0]     wr_addr;
   logic [NWR*ROB_W-1:0]  wr_tag;
   logic [NWR*XLEN-1:0]   wr_data;
   logic [NREN-1:0]       ren_en;
   logic [NREN*AW-1:0]    ren_addr;
   logic [NREN*ROB_W-1:0] ren_tag;
   logic                  flush;
   logic [AW:0]           busy_cnt;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_tag, wr_data, ren_en, ren_addr, ren_tag, flush,
      input  rd_data, rd_tag, rd_avail, busy_cnt
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_tag, wr_data, ren_en, ren_addr, ren_tag, flush,
      output rd_data, rd_tag, rd_avail, busy_cnt
   );
endinterface

// File: rtl/int_reg_file_rob.sv
// Architectural integer register file with per-register ROB tag / available status.
// Optional READ_BYPASS_EN: forwards same-cycle commit data (and release status) to reads.
module int_reg_file_rob #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int ROB_W = 4,
   parameter int NRD   = 4,
   parameter int NWR   = 2,
   parameter int NREN  = 2
) (
   input logic              clk,
   input logic              rst_n,
   int_reg_file_rob_if.slave bus
);
   localparam int AW = $clog2(NREG);
   localparam int CW = AW + 1;

   logic [XLEN-1:0]     data_r [NREG];
   logic [ROB_W-1:0]    tag_r  [NREG];
   logic [NREG-1:0]     avail_r;
   logic [CW-1:0]       busy_r;

   logic [XLEN-1:0]     data_s [NREG];
   logic [ROB_W-1:0]    tag_s  [NREG];
   logic [NREG-1:0]     avail_s;
   logic [NREG-1:0]     rel_s;
   logic [CW-1:0]       busy_s;

   logic [AW-1:0]       ra_s [NRD];
   logic [AW-1:0]       wa_s [NWR];
   logic [ROB_W-1:0]    wt_s [NWR];
   logic [XLEN-1:0]     wd_s [NWR];
   logic [AW-1:0]       na_s [NREN];
   logic [ROB_W-1:0]    nt_s [NREN];

   logic [NRD*XLEN-1:0]  rd_data_s;
   logic [NRD*ROB_W-1:0] rd_tag_s;
   logic [NRD-1:0]       rd_avail_s;

   function automatic logic [CW-1:0] count_busy(input logic [NREG-1:0] avail);
      logic [CW-1:0] n;
      n = '0;
      for (int r = 1; r < NREG; r++) begin
         if (!avail[r]) n = n + CW'(1'b1);
         else           n = n;
      end
      return n;
   endfunction

   // Unpack the flat port buses into per-port fields
   always_comb begin
      for (int k = 0; k < NRD; k++) ra_s[k] = bus.rd_addr[k*AW +: AW];
      for (int j = 0; j < NWR; j++) begin
         wa_s[j] = bus.wr_addr[j*AW +: AW];
         wt_s[j] = bus.wr_tag[j*ROB_W +: ROB_W];
         wd_s[j] = bus.wr_data[j*XLEN +: XLEN];
      end
      for (int i = 0; i < NREN; i++) begin
         na_s[i] = bus.ren_addr[i*AW +: AW];
         nt_s[i] = bus.ren_tag[i*ROB_W +: ROB_W];
      end
   end

   // Registers released by a commit whose tag matches the pre-edge pending tag
   always_comb begin
      rel_s = '0;
      for (int j = 0; j < NWR; j++) begin
         if (bus.wr_en[j] && (wa_s[j] != '0) && !avail_r[wa_s[j]] && (tag_r[wa_s[j]] == wt_s[j]))
            rel_s[wa_s[j]] = 1'b1;
         else
            rel_s = rel_s;
      end
   end

   // Next state: data from commits; status from flush, else releases then renames
   always_comb begin
      data_s  = data_r;
      tag_s   = tag_r;
      avail_s = avail_r;
      for (int j = 0; j < NWR; j++) begin
         if (bus.wr_en[j] && (wa_s[j] != '0)) data_s[wa_s[j]] = wd_s[j];
         else                                 data_s[wa_s[j]] = data_s[wa_s[j]];
      end
      if (bus.flush) begin
         for (int r = 0; r < NREG; r++) tag_s[r] = '0;
         avail_s = '1;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (rel_s[r]) begin
               tag_s[r]   = '0;
               avail_s[r] = 1'b1;
            end else begin
               tag_s[r]   = tag_s[r];
            end
         end
         // Later rename ports are younger, so they overwrite earlier ones and any release
         for (int i = 0; i < NREN; i++) begin
            if (bus.ren_en[i] && (na_s[i] != '0)) begin
               tag_s[na_s[i]]   = nt_s[i];
               avail_s[na_s[i]] = 1'b0;
            end else begin
               avail_s = avail_s;
            end
         end
      end
      busy_s = count_busy(avail_s);
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            data_r[r] <= '0;
            tag_r[r]  <= '0;
         end
         avail_r <= '1;
         busy_r  <= '0;
      end else begin
         data_r  <= data_s;
         tag_r   <= tag_s;
         avail_r <= avail_s;
         busy_r  <= busy_s;
      end
   end

   // Combinational read ports; r0 is hardwired to zero / available
   always_comb begin
      rd_data_s  = '0;
      rd_tag_s   = '0;
      rd_avail_s = '1;
      for (int k = 0; k < NRD; k++) begin
         if (ra_s[k] != '0) begin
            rd_data_s[k*XLEN +: XLEN]   = data_r[ra_s[k]];
            rd_tag_s[k*ROB_W +: ROB_W]  = tag_r[ra_s[k]];
            rd_avail_s[k]               = avail_r[ra_s[k]];
`ifdef READ_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
               if (bus.wr_en[j] && (wa_s[j] == ra_s[k])) begin
                  rd_data_s[k*XLEN +: XLEN] = wd_s[j];
                  if (rel_s[ra_s[k]]) begin
                     rd_tag_s[k*ROB_W +: ROB_W] = '0;
                     rd_avail_s[k]              = 1'b1;
                  end else begin
                     rd_avail_s[k]              = rd_avail_s[k];
                  end
               end else begin
                  rd_avail_s[k] = rd_avail_s[k];
               end
            end
`endif
         end else begin
            rd_data_s[k*XLEN +: XLEN]  = '0;
            rd_tag_s[k*ROB_W +: ROB_W] = '0;
            rd_avail_s[k]              = 1'b1;
         end
      end
   end

   assign bus.rd_data  = rd_data_s;
   assign bus.rd_tag   = rd_tag_s;
   assign bus.rd_avail = rd_avail_s;
   assign bus.busy_cnt = busy_r;

endmodule

// File: tb/tb_int_reg_file_rob.sv
// Scoreboard bench for int_reg_file_rob; expectations follow READ_BYPASS_EN when defined.
module tb_int_reg_file_rob;
   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int ROB_W = 4;
   localparam int NRD   = 4;
   localparam int NWR   = 2;
   localparam int NREN  = 2;
   localparam int AW    = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int_reg_file_rob_if #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NRD(NRD), .NWR(NWR), .NREN(NREN)) bus ();

   int_reg_file_rob #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NRD(NRD), .NWR(NWR), .NREN(NREN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      int          cyc;
      bit          is_busy;
      int          port;
      logic [31:0] data;
      logic [3:0]  tag;
      logic        avail;
      logic [5:0]  busy;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: the read ports are sampled at the falling edge of the cycle each entry was issued in
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         total++;
         if (e.cyc != cyc) begin
            bad++;
            $display("FAIL %s: expectation from cycle %0d still queued at cycle %0d", e.name, e.cyc, cyc);
         end else if (e.is_busy) begin
            if (bus.busy_cnt !== e.busy) begin
               bad++;
               $display("FAIL %s: busy_cnt got %0d want %0d", e.name, bus.busy_cnt, e.busy);
            end
         end else if (bus.rd_data[e.port*XLEN +: XLEN] !== e.data ||
                      bus.rd_tag[e.port*ROB_W +: ROB_W] !== e.tag ||
                      bus.rd_avail[e.port] !== e.avail) begin
            bad++;
            $display("FAIL %s: port %0d got data=%h tag=%0d avail=%b want data=%h tag=%0d avail=%b",
                     e.name, e.port, bus.rd_data[e.port*XLEN +: XLEN], bus.rd_tag[e.port*ROB_W +: ROB_W],
                     bus.rd_avail[e.port], e.data, e.tag, e.avail);
         end
      end
   end

   task automatic exp_rd(input string name, input int k, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] t, input logic av);
      exp_t x;
      bus.rd_addr[k*AW +: AW] = a;
      x.name = name; x.cyc = cyc; x.is_busy = 1'b0; x.port = k;
      x.data = d; x.tag = t; x.avail = av; x.busy = 6'd0;
      sb.push_back(x);
   endtask

   task automatic exp_busy(input string name, input logic [5:0] b);
      exp_t x;
      x.name = name; x.cyc = cyc; x.is_busy = 1'b1; x.port = 0;
      x.data = 32'd0; x.tag = 4'd0; x.avail = 1'b0; x.busy = b;
      sb.push_back(x);
   endtask

   task automatic commit(input int j, input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
      bus.wr_en[j]                 = 1'b1;
      bus.wr_addr[j*AW +: AW]      = a;
      bus.wr_tag[j*ROB_W +: ROB_W] = t;
      bus.wr_data[j*XLEN +: XLEN]  = d;
   endtask

   task automatic rename(input int i, input logic [4:0] a, input logic [3:0] t);
      bus.ren_en[i]                 = 1'b1;
      bus.ren_addr[i*AW +: AW]      = a;
      bus.ren_tag[i*ROB_W +: ROB_W] = t;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      bus.wr_en  = '0;
      bus.ren_en = '0;
      bus.flush  = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.rd_addr  = '0;
      bus.wr_en    = '0;
      bus.wr_addr  = '0;
      bus.wr_tag   = '0;
      bus.wr_data  = '0;
      bus.ren_en   = '0;
      bus.ren_addr = '0;
      bus.ren_tag  = '0;
      bus.flush    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int r = 1; r < 32; r++) begin
         exp_rd("reset_read", r % 4, 5'(r), 32'd0, 4'd0, 1'b1);
         if (r % 4 == 3) step();
      end
      exp_busy("reset_busy", 6'd0);

      commit(0, 5'd0, 4'd0, 32'hFFFF_FFFF);
      step();
      exp_rd("r0_write", 0, 5'd0, 32'd0, 4'd0, 1'b1);

      rename(0, 5'd5, 4'd3);
      step();
      exp_rd("ren_r5", 1, 5'd5, 32'd0, 4'd3, 1'b0);
      exp_busy("ren_r5_busy", 6'd1);
      commit(1, 5'd5, 4'd3, 32'h0000_1234);
      step();
      exp_rd("commit_r5", 1, 5'd5, 32'h0000_1234, 4'd0, 1'b1);
      exp_busy("commit_r5_busy", 6'd0);

      rename(0, 5'd7, 4'd2);
      step();
      rename(0, 5'd7, 4'd6);
      step();
      exp_rd("ren_r7_twice", 0, 5'd7, 32'd0, 4'd6, 1'b0);
      commit(0, 5'd7, 4'd2, 32'h0000_00AA);
      step();
      exp_rd("r7_stale_commit", 0, 5'd7, 32'h0000_00AA, 4'd6, 1'b0);
      exp_busy("r7_stale_busy", 6'd1);
      commit(0, 5'd7, 4'd6, 32'h0000_00BB);
      step();
      exp_rd("r7_final_commit", 0, 5'd7, 32'h0000_00BB, 4'd0, 1'b1);
      exp_busy("r7_final_busy", 6'd0);

      rename(0, 5'd9, 4'd8);
      step();
      rename(0, 5'd9, 4'd1);
      rename(1, 5'd9, 4'd4);
      commit(0, 5'd9, 4'd8, 32'h0000_0055);
      step();
      exp_rd("r9_ren_vs_commit", 2, 5'd9, 32'h0000_0055, 4'd4, 1'b0);
      exp_busy("r9_busy", 6'd1);

      rename(0, 5'd2, 4'd1);
      rename(1, 5'd3, 4'd2);
      step();
      rename(0, 5'd4, 4'd3);
      step();
      exp_busy("pre_flush_busy", 6'd4);
      bus.flush = 1'b1;
      commit(0, 5'd2, 4'd1, 32'h0000_0077);
      rename(0, 5'd6, 4'd5);
      step();
      exp_rd("flush_r2", 0, 5'd2, 32'h0000_0077, 4'd0, 1'b1);
      exp_rd("flush_r3", 1, 5'd3, 32'd0, 4'd0, 1'b1);
      exp_rd("flush_r4", 2, 5'd4, 32'd0, 4'd0, 1'b1);
      exp_rd("flush_r6", 3, 5'd6, 32'd0, 4'd0, 1'b1);
      exp_busy("flush_busy", 6'd0);
      step();
      exp_rd("flush_r9", 0, 5'd9, 32'h0000_0055, 4'd0, 1'b1);

      rename(0, 5'd11, 4'd9);
      step();
      commit(0, 5'd11, 4'd9, 32'h0000_0111);
      commit(1, 5'd11, 4'd2, 32'h0000_0222);
      step();
      exp_rd("dual_commit_r11", 1, 5'd11, 32'h0000_0222, 4'd0, 1'b1);
      exp_busy("dual_commit_busy", 6'd0);

      rename(0, 5'd10, 4'd5);
      step();
      commit(0, 5'd10, 4'd5, 32'h0000_CAFE);
`ifdef READ_BYPASS_EN
      exp_rd("bypass_r10", 2, 5'd10, 32'h0000_CAFE, 4'd0, 1'b1);
`else
      exp_rd("nobypass_r10", 2, 5'd10, 32'd0, 4'd5, 1'b0);
`endif
      step();
      exp_rd("after_commit_r10", 2, 5'd10, 32'h0000_CAFE, 4'd0, 1'b1);
      exp_busy("after_commit_busy", 6'd0);

      for (int r = 1; r < 32; r += 2) begin
         rename(0, 5'(r), 4'(r));
         if (r + 1 < 32) rename(1, 5'(r + 1), 4'(r + 1));
         step();
      end
      exp_busy("busy_full", 6'd31);
      exp_rd("full_r31", 3, 5'd31, 32'd0, 4'd15, 1'b0);
      bus.flush = 1'b1;
      step();
      exp_busy("full_flush_busy", 6'd0);

      rename(0, 5'd0, 4'd7);
      step();
      exp_rd("ren_r0", 0, 5'd0, 32'd0, 4'd0, 1'b1);
      exp_busy("ren_r0_busy", 6'd0);

      repeat (2) step();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/int_reg_file_rob.md
Name: int_reg_file_rob

Overview:
Parametrised architectural integer register file with per-register rename status (ROB tag + available bit) for the out-of-order core. Sits between decode/rename and the ROB commit stage. Successor of the fixed 31x32, 4-read/2-write status-tracking file. Adds parametrised widths and port counts, flush recovery, a same-cycle commit/rename priority contract and a live busy-register count.

Parameters:
XLEN, 32, data width
NREG, 32, architectural registers including r0; power of two, 2..64
ROB_W, 4, ROB tag width
NRD, 4, read ports
NWR, 2, commit (write) ports
NREN, 2, rename (allocate) ports

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
rd_addr  in  NRD*log2(NREG)  read register numbers, port k at slice k
rd_data  out  NRD*XLEN  read data
rd_tag  out  NRD*ROB_W  pending ROB tag; 0 when available
rd_avail  out  NRD  1 = value in file is current
wr_en  in  NWR  commit write enable per port
wr_addr  in  NWR*log2(NREG)  commit destination
wr_tag  in  NWR*ROB_W  committing ROB entry
wr_data  in  NWR*XLEN  commit data
ren_en  in  NREN  rename allocate enable; port order = program order
ren_addr  in  NREN*log2(NREG)  destination being renamed
ren_tag  in  NREN*ROB_W  ROB tag allocated
flush  in  1  discard all pending renames
busy_cnt  out  log2(NREG)+1  registers with avail=0 (registered)

Behaviour:
- Async reset: all data 0, all tags 0, all avail 1, busy_cnt 0. Reset mid-cycle overrides every pending update.
- r0: reads always data 0, tag 0, avail 1. Writes and renames to r0 are ignored.
- Reads are combinational. They reflect the registered state, subject to the optional bypass.
- Renames in a cycle are not visible on reads until the next cycle.
- Commit write on port j, at posedge: data[wr_addr] <= wr_data whenever wr_en. The data is written even if the tag mismatches, because the architectural value must be kept.
- If the pre-edge tag[wr_addr] == wr_tag and avail == 0, the register is released: avail <= 1, tag <= 0.
- A tag mismatch leaves the status unchanged, because a younger rename is outstanding.
- Rename port i, at posedge: tag[ren_addr] <= ren_tag and avail <= 0.
- Same register on several rename ports: the highest-index port wins.
- Rename and a releasing commit to the same register in one cycle: the data is written, and the rename wins the status (avail 0, new tag).
- Two commit ports to the same register: the highest-index port wins the data. The release applies if either port's tag matches.
- flush at posedge: every register gets avail <= 1, tag <= 0. Renames in the same cycle are dropped. Commit data writes in the same cycle still occur.
- busy_cnt: registered popcount of avail==0 over r1..NREG-1, computed from the next-state, so it is valid in the same cycle as the state. It never exceeds NREG-1.
- No X on outputs for any in-range address.

Optional Feature:
READ_BYPASS_EN
- Defined: if a read address equals an enabled commit's wr_addr (non-zero) in the same cycle, rd_data returns wr_data.
- If that commit would also release the register (tag match), rd_avail=1 and rd_tag=0 that cycle.
- If several commit ports hit the same address, the highest-index port is forwarded.
- Undefined: reads show registered state only, so commit-to-read latency is 1 cycle.

Test Plan:
- Reset → read r1..r31: data 0, avail 1, tag 0; busy_cnt 0. Write r0=0xFFFF_FFFF → r0 still reads 0.
- Rename r5 with tag 3 → next cycle rd_avail=0, rd_tag=3, busy_cnt=1. Commit r5 tag 3 data 0x1234 → next cycle data 0x1234, avail 1, busy_cnt 0.
- Rename r7 with tag 2, then tag 6. Commit r7 tag 2 data 0xAA → data 0xAA, avail 0, tag 6. Commit tag 6 data 0xBB → data 0xBB, avail 1.
- Same cycle: ren port0 r9 tag1, ren port1 r9 tag4, commit r9 (prior tag match) data 0x55 → data 0x55, tag 4, avail 0.
- Rename r2, r3, r4; flush together with commit r2 data 0x77 and rename r6 → all avail 1, r2=0x77, r6 not busy, busy_cnt 0.
- READ_BYPASS_EN: r10 pending tag 5. Commit r10 tag 5 data 0xCAFE while reading r10 → same cycle rd_data 0xCAFE, rd_avail 1. Without the macro → old data, avail 0, updated next cycle.
